sc_io_port: RTL and testbench

- Memory-mapped I/O responder on the single-cycle CPU data bus.
- Serves the I/O address window that the data memory forwards to it.
- Synchronizes and debounces the 10 board switches, latches per-switch change events, and holds the LED and hex-display registers.
- Drives active-low seven-segment outputs for six hex digits.
- Sequential state: synchronizers, debounce counters, sticky event flags, control registers.

---
 rtl/sc_io_pkg.sv | 49 ++++
 rtl/sc_io_if.sv | 23 ++
 rtl/sc_io_debounce.sv | 59 +++++
 rtl/sc_io_port.sv | 113 +++++++++++
 tb/tb_sc_io_port.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_io_pkg
// Description : Shared definitions for the sc_io_port I/O responder.
//               - Register indices, decoded from addr[4:2].
//               - Seven-segment glyph table (active-low, gfedcba).
//               - Blank-digit constant.
//               - seg7_decode helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_io_pkg;

  localparam logic [2:0] REG_SW   = 3'd0;
  localparam logic [2:0] REG_EVT  = 3'd1;
  localparam logic [2:0] REG_LED  = 3'd2;
  localparam logic [2:0] REG_HEX  = 3'd3;
  localparam logic [2:0] REG_CTRL = 3'd4;

  localparam int NUM_SW     = 10;
  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Element n holds the glyph for nibble value n (entry 15 is listed first).
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    return SEG_GLYPHS[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_io_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_io_if
// Description : CPU data-bus connection for the I/O window.
//   sel   - window select, qualifies reads and writes
//   addr  - byte address (addr[4:2] selects the register)
//   wdata - write data
//   we    - write enable
//   rdata - zero-latency read data
//   master : CPU side, slave : I/O responder side
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_io_if;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output sel, output addr, output wdata, output we, input rdata);
  modport slave  (input sel, input addr, input wdata, input we, output rdata);
endinterface
`default_nettype wire

// File: rtl/sc_io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sc_io_debounce
// Description : Single-bit two-flop synchronizer followed by a debounce
//               counter.
//   clock  - system clock
//   reset  - asynchronous active-high reset
//   din    - raw asynchronous input
//   stable - debounced level
//   change - high for the one cycle whose rising edge updates stable
// Revision    : 1.0 - initial release
// ============================================================================
module sc_io_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // The counter holds the number of mismatching samples already seen, so the
  // DEB_CYCLES-th consecutive mismatch is the one that sees CNT_LAST.
  // The pulse is combinational so the event flag sets on the same edge that
  // updates stable.
  assign change = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);
  assign stable = r_stable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (change) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_io_port.sv
`default_nettype none
// ============================================================================
// Module      : sc_io_port
// Description : Memory-mapped I/O responder for the single-cycle CPU.
//               - Debounces 10 switches and latches sticky change events.
//               - Holds the LED, HEX and CTRL registers.
//               - Drives six active-low seven-segment digits.
//   clock      - system clock
//   reset      - asynchronous active-high reset
//   bus        - sc_io_if slave (sel/addr/wdata/we/rdata)
//   io_in_sw   - raw switch inputs
//   io_out_led - LED register
//   io_out_hex - 6 x 7 segments, active-low, gfedcba
//   irq        - irq_en & any event pending
// Revision    : 1.0 - initial release
// ============================================================================
module sc_io_port
  import sc_io_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  sc_io_if.slave                  bus,
  input  logic [NUM_SW-1:0]       io_in_sw,
  output logic [NUM_SW-1:0]       io_out_led,
  output logic [7*NUM_DIGITS-1:0] io_out_hex,
  output logic                    irq
);

  logic [2:0]              w_idx;
  logic                    w_wr;
  logic [NUM_SW-1:0]       w_sw;
  logic [NUM_SW-1:0]       w_chg;
  logic [NUM_SW-1:0]       w_evt_clr;
  logic [7*NUM_DIGITS-1:0] w_glyphs;
  logic                    w_unused_bits;

  logic [NUM_SW-1:0]       r_evt;
  logic [NUM_SW-1:0]       r_led;
  logic [23:0]             r_hex;
  logic [1:0]              r_ctrl;

  assign w_idx = bus.addr[4:2];
  assign w_wr  = bus.sel & bus.we;

  // Address/data bits outside the decoded fields are intentionally ignored.
  assign w_unused_bits = &{1'b0, bus.addr[31:5], bus.addr[1:0], bus.wdata[31:24]};

  generate
    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      sc_io_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
      ) u_deb (
        .clock  (clock),
        .reset  (reset),
        .din    (io_in_sw[i]),
        .stable (w_sw[i]),
        .change (w_chg[i])
      );
    end
  endgenerate

  assign w_evt_clr = (w_wr && (w_idx == REG_EVT)) ? bus.wdata[NUM_SW-1:0] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_evt  <= '0;
      r_led  <= '0;
      r_hex  <= '0;
      r_ctrl <= '0;
    end else begin
      // Set is OR-ed in after the clear so a simultaneous set wins.
      r_evt <= (r_evt & ~w_evt_clr) | w_chg;
      if (w_wr) begin
        case (w_idx)
          REG_LED:  r_led  <= bus.wdata[NUM_SW-1:0];
          REG_HEX:  r_hex  <= bus.wdata[23:0];
          REG_CTRL: r_ctrl <= bus.wdata[1:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (w_idx)
        REG_SW:   bus.rdata = {22'd0, w_sw};
        REG_EVT:  bus.rdata = {22'd0, r_evt};
        REG_LED:  bus.rdata = {22'd0, r_led};
        REG_HEX:  bus.rdata = {8'd0, r_hex};
        REG_CTRL: bus.rdata = {30'd0, r_ctrl};
        default:  bus.rdata = '0;
      endcase
    end
  end

  generate
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      assign w_glyphs[7*d +: 7] = seg7_decode(r_hex[4*d +: 4]);
    end
  endgenerate

  assign io_out_hex = r_ctrl[1] ? {NUM_DIGITS{SEG_BLANK}} : w_glyphs;
  assign io_out_led = r_led;
  assign irq        = r_ctrl[0] & (|r_evt);

endmodule
`default_nettype wire

// File: tb/tb_sc_io_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_io_port
// Description : Self-checking bench for sc_io_port (DEB_CYCLES=4), directed
//               steps followed by randomized bus/switch traffic checked
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_io_port;

  localparam int DEB = 4;

  logic        clock;
  logic        reset;
  logic [9:0]  sw;
  logic [9:0]  led;
  logic [41:0] hex;
  logic        irq;

  int vectors;
  int miscompares;

  sc_io_if bus ();

  sc_io_port #(
    .DEB_CYCLES (DEB),
    .CNT_W      (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .io_in_sw   (sw),
    .io_out_led (led),
    .io_out_hex (hex),
    .irq        (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [9:0]  m_stable, m_evt, m_led;
  logic [23:0] m_hex;
  logic [1:0]  m_ctrl;
  logic [9:0]  raw_q [$];   // raw pin values seen at the last three edges
  logic [9:0]  s_q   [$];   // synchronized samples used at the last DEB edges

  task automatic model_clear();
    m_stable = '0; m_evt = '0; m_led = '0; m_hex = '0; m_ctrl = '0;
    raw_q.delete();
    s_q.delete();
  endtask

  // One rising edge: a bit's debounced value flips when the last DEB
  // synchronized samples all disagree with it; the synchronized sample is
  // the pin value from two edges earlier.
  task automatic model_edge(input logic [9:0] raw, input logic s_sel, input logic s_we,
                            input logic [31:0] a, input logic [31:0] d);
    logic [9:0] s, set, clr;
    logic all_diff;
    raw_q.push_back(raw);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    s = (raw_q.size() == 3) ? raw_q[0] : 10'd0;
    s_q.push_back(s);
    if (s_q.size() > DEB) void'(s_q.pop_front());
    set = '0;
    if (s_q.size() == DEB) begin
      for (int b = 0; b < 10; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (s_q[k][b] == m_stable[b]) all_diff = 1'b0;
        set[b] = all_diff;
      end
    end
    m_stable = m_stable ^ set;
    clr = (s_sel && s_we && a[4:2] == 3'd1) ? d[9:0] : 10'd0;
    m_evt = (m_evt & ~clr) | set;
    if (s_sel && s_we) begin
      case (a[4:2])
        3'd2: m_led  = d[9:0];
        3'd3: m_hex  = d[23:0];
        3'd4: m_ctrl = d[1:0];
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic s_sel, input logic [31:0] a);
    if (!s_sel) return 32'd0;
    case (a[4:2])
      3'd0:    return {22'd0, m_stable};
      3'd1:    return {22'd0, m_evt};
      3'd2:    return {22'd0, m_led};
      3'd3:    return {8'd0, m_hex};
      3'd4:    return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex();
    logic [41:0] h;
    if (m_ctrl[1]) return {42{1'b1}};
    for (int i = 0; i < 6; i++) h[7*i +: 7] = glyph[m_hex[4*i +: 4]];
    return h;
  endfunction

  // ---------------- checking / driving helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("led", {54'd0, led}, {54'd0, m_led});
    chk("irq", {63'd0, irq}, {63'd0, (m_ctrl[0] & (|m_evt))});
    chk("hex", {22'd0, hex}, {22'd0, exp_hex()});
  endtask

  task automatic tick();
    logic [9:0] c_sw;
    logic c_sel, c_we, c_rst;
    logic [31:0] c_a, c_d;
    c_sw = sw; c_sel = bus.sel; c_we = bus.we; c_a = bus.addr; c_d = bus.wdata; c_rst = reset;
    @(posedge clock);
    if (c_rst) model_clear();
    else model_edge(c_sw, c_sel, c_we, c_a, c_d);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    v = bus.rdata;
    chk($sformatf("rdata@%0h", a), {32'd0, v}, {32'd0, exp_rdata(1'b1, a)});
    bus.sel = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0; bus.sel = 1'b0;
  endtask

  task automatic do_reset();
    logic [31:0] v;
    reset = 1'b1;
    model_clear();
    #1;
    check_outputs();
    chk("rst_hex_lit", {22'd0, hex}, {22'd0, {6{7'b1000000}}});
    for (int i = 0; i < 8; i++) begin
      rd(32'(i * 4), v);
      chk("rst_rdata_lit", {32'd0, v}, 64'd0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    logic [31:0] a;
    vectors = 0;
    miscompares = 0;
    sw = '0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clock);
    do_reset();

    // Debounce latency: 2 sync + DEB cycles
    sw[3] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      rd(32'h0, v); chk("deb_wait", {32'd0, v}, 64'h0);
    end
    tick();
    rd(32'h0, v); chk("deb_done", {32'd0, v}, 64'h8);
    rd(32'h4, v); chk("deb_evt", {32'd0, v}, 64'h8);
    wr(32'h4, 32'h8);
    rd(32'h4, v); chk("evt_clr", {32'd0, v}, 64'h0);

    // Glitch of DEB-1 cycles is rejected
    sw[0] = 1'b1;
    repeat (3) tick();
    sw[0] = 1'b0;
    repeat (12) tick();
    rd(32'h0, v); chk("glitch_sw", {32'd0, v}, 64'h8);
    rd(32'h4, v); chk("glitch_evt", {32'd0, v}, 64'h0);

    // W1C on the same edge as a debounce set: set wins
    sw[3] = 1'b0;
    repeat (5) tick();
    wr(32'h4, 32'h8);
    rd(32'h4, v); chk("race_evt", {32'd0, v}, 64'h8);
    rd(32'h0, v); chk("race_sw", {32'd0, v}, 64'h0);

    // IRQ
    wr(32'h10, 32'h1);
    chk("irq_on", {63'd0, irq}, 64'd1);
    wr(32'h4, 32'h8);
    rd(32'h4, v); chk("evt_clr2", {32'd0, v}, 64'h0);
    chk("irq_off", {63'd0, irq}, 64'd0);

    // LED
    wr(32'h8, 32'h3FF);
    chk("led_lit", {54'd0, led}, 64'h3FF);
    wr(32'h8, 32'hFFFF_FFFF);
    rd(32'h8, v); chk("led_mask", {32'd0, v}, 64'h3FF);

    // HEX and blank
    wr(32'hC, 32'h00A810);
    chk("hex_lit", {22'd0, hex},
        {22'd0, 7'b1000000, 7'b1000000, 7'b0001000, 7'b0000000, 7'b1111001, 7'b1000000});
    wr(32'h10, 32'h2);
    chk("hex_blank", {22'd0, hex}, {22'd0, {42{1'b1}}});
    wr(32'h1C, 32'hFFFF_FFFF);
    rd(32'h1C, v); chk("addr7", {32'd0, v}, 64'h0);
    check_outputs();

    // Reset in the middle of a pending change
    sw = 10'h0F0;
    repeat (4) tick();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      tick();
      rd(32'h0, v); chk("rst_deb_wait", {32'd0, v}, 64'h0);
    end
    tick();
    rd(32'h0, v); chk("rst_deb_done", {32'd0, v}, 64'h0F0);
    rd(32'h4, v); chk("rst_deb_evt", {32'd0, v}, 64'h0F0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 10; b++)
        if ($urandom_range(0, 11) == 0) sw[b] = ~sw[b];
      a = $urandom;
      a[4:2] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        wr(a, $urandom);
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          bus.sel = 1'b0; bus.we = 1'b0; bus.addr = a;
          #1;
          chk("rdata_nosel", {32'd0, bus.rdata}, 64'd0);
        end else begin
          rd(a, v);
        end
        tick();
      end
      check_outputs();
    end

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
